prx32_rom_streamer: RTL and testbench
=====================================

# prx32_rom_streamer

Read initiator for the `prx32_memory` 4 KB synchronous-read ROM. On a `start` command it issues sequential word addresses from a base address. It absorbs the memory's fixed read latency and presents the words as a valid/ready stream with a last-beat marker. It sits between the ROM and any consumer that loads ROM contents, such as a boot or program copier.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: ROM size in 32-bit words. The byte range is 0x000 to 4*DEPTH_WORDS-1.
- `FIFO_DEPTH`, default 4: output buffer entries. Must be at least 3.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: command strobe. Sampled only in IDLE.
- `base_addr`, in, 32: byte address of the first word. Sampled with `start`.
- `word_count`, in, 11: number of words to read, 0 to 1024. Sampled with `start`.
- `mem_addr`, out, 32: registered address to the ROM `addr` port.
- `mem_rdata`, in, 32: ROM `rdata`.
- `m_valid`, out, 1: stream data valid.
- `m_ready`, in, 1: consumer accepts.
- `m_data`, out, 32: stream word.
- `m_last`, out, 1: high with the final word of a command.
- `busy`, out, 1: high while in RUN or DRAIN.
- `done`, out, 1: one-cycle pulse when a command completes.
- `err`, out, 1: one-cycle pulse when a command is rejected.

## Operation
- FSM states are IDLE, RUN, DRAIN.
- IDLE:
  - `start`=1 with a valid command: latch base and count, and go to RUN.
  - `word_count`=0: pulse `done` on the next cycle and stay in IDLE.
  - Invalid command: pulse `err`. No read is issued. `mem_addr` is unchanged.
- A command is valid when:
  - `base_addr[1:0]`=0, and
  - `base_addr + 4*word_count <= 4*DEPTH_WORDS`. This check uses 33-bit arithmetic so there is no overflow.
- RUN:
  - A read is issued when `fifo_count + inflight < FIFO_DEPTH`.
  - An issue loads `mem_addr` with the next address, then increments it by 4 and decrements the remaining count.
  - After the last issue, go to DRAIN.
- In-flight tracking:
  - A 2-stage issue shift register tracks outstanding reads.
  - The stage-2 bit pushes `mem_rdata` into the FIFO.
  - A beat leaves the FIFO on `m_valid & m_ready`.
- DRAIN: when the final beat is accepted (`m_last & m_ready`), go to IDLE. `done` pulses on the following cycle.
- `start` is ignored outside IDLE.
- FIFO push and pop in the same cycle are both allowed; `fifo_count` is unchanged.
- While a beat is stalled (`m_valid`=1 and `m_ready`=0), `m_data` and `m_last` hold stable.
- Asynchronous reset:
  - Clears the FSM, counters, FIFO, and in-flight bits.
  - Discards all pending beats.
  - Sets `mem_addr`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0, `err`=0.
- `mem_addr` holds its last value in IDLE.

## Timing
- With `start` sampled at edge k:
  - `mem_addr` = base after edge k.
  - The ROM samples it at edge k+1.
  - Data is captured at edge k+2.
  - `m_valid`=1 after edge k+2.
- Throughput is 1 word per cycle while `m_ready`=1.
- Consecutive issued addresses appear on consecutive cycles.
- `done` is asserted the cycle after the edge at which the last beat handshakes.
- `err` is asserted the cycle after the edge at which the invalid `start` is sampled.
- `busy` rises after the start edge and falls together with the `done` pulse.

## Configuration
- `PRX32_ROM_STREAMER_WRAP_EN`:
  - Defined: the address wraps modulo 4*DEPTH_WORDS, so 0xFFC is followed by 0x000. The range check is skipped; only the alignment error remains.
  - Undefined: a range overflow raises `err` as described in Operation.

## Test plan
ROM is preloaded with 0x1, 0x3, 0x7, 0xF, 0xFF at byte addresses 0x00 to 0x10.
- `start`, base=0x0, count=5, `m_ready`=1 → beats 0x1, 0x3, 0x7, 0xF, 0xFF on 5 consecutive cycles. First beat at k+2. `m_last` only on 0xFF. `done` one cycle later.
- Same command with `m_ready` high 1 cycle in 3 → identical sequence with no loss or duplication. `m_data` stable during stalls. The FIFO never overflows.
- base=0x002, count=1 → `err` pulse. `busy`, `m_valid`, and `mem_addr` unchanged.
- base=0xFFC, count=3 → without the macro, `err`. With the macro, words from 0xFFC, 0x000, 0x004, where the last two are 0x1 and 0x3.
- count=0 → `done` pulse only. `m_valid` never asserted.
- `rst` pulsed after 2 beats are accepted → all outputs take reset values asynchronously. A new `start` with base=0x8, count=1 yields 0x7 with `m_last`.

Source files
------------

// File: rtl/prx32_rom_streamer_if.sv
// Output stream bundle of prx32_rom_streamer: valid/ready handshake carrying
// one 32-bit ROM word per beat, plus an end-of-command marker.
interface prx32_rom_streamer_if;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;

   modport master (output m_valid, output m_data, output m_last, input m_ready);
   modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/prx32_rom_streamer.sv
// Sequential read initiator for the prx32 synchronous ROM; hides the 2-cycle read
// latency behind a small FIFO. Define PRX32_ROM_STREAMER_WRAP_EN for wrapping addresses.
module prx32_rom_streamer #(
   parameter int DEPTH_WORDS = 1024,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [31:0]                  base_addr,
   input  logic [10:0]                  word_count,
   output logic [31:0]                  mem_addr,
   input  logic [31:0]                  mem_rdata,
   prx32_rom_streamer_if.master         strm,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state_reg, state_next;
   logic [31:0]   mem_addr_reg, next_addr_reg;
   logic [10:0]   remaining_reg;
   logic          s1_reg, s1_last_reg, s2_reg, s2_last_reg;
   logic          done_reg, err_reg;
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] fifo_count_reg;
   logic [31:0]   entry_data [FIFO_DEPTH];
   logic          entry_last [FIFO_DEPTH];

   logic          issue, cmd_load, issue_last, done_next, err_next, cmd_ok;
   logic          push, pop;
   logic [31:0]   issue_addr, addr_inc;
   logic [CW:0]   occupancy;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

`ifdef PRX32_ROM_STREAMER_WRAP_EN
   assign cmd_ok = (base_addr[1:0] == 2'b00);
   always_comb begin
      addr_inc = issue_addr + 32'd4;
      if (addr_inc >= BYTE_LIMIT)
         addr_inc = '0;
   end
`else
   // 33-bit sum so a base near 2^32 cannot wrap around and pass the range check
   assign cmd_ok = (base_addr[1:0] == 2'b00) &&
                   (({1'b0, base_addr} + {20'b0, word_count, 2'b00}) <= {1'b0, BYTE_LIMIT});
   assign addr_inc = issue_addr + 32'd4;
`endif

   assign push       = s2_reg;
   assign pop        = strm.m_valid & strm.m_ready;
   assign occupancy  = {1'b0, fifo_count_reg} + (CW + 1)'(s1_reg) + (CW + 1)'(s2_reg);
   assign issue_addr = cmd_load ? base_addr : next_addr_reg;
   assign issue_last = cmd_load ? (word_count == 11'd1) : (remaining_reg == 11'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      cmd_load   = 1'b0;
      done_next  = 1'b0;
      err_next   = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (start) begin
               if (!cmd_ok)
                  err_next = 1'b1;
               else if (word_count == 11'd0)
                  done_next = 1'b1;
               else begin
                  // first read goes out on the start edge itself
                  cmd_load   = 1'b1;
                  issue      = 1'b1;
                  state_next = (word_count == 11'd1) ? DRAIN : RUN;
               end
            end
         end
         RUN: begin
            if (occupancy < (CW + 1)'(FIFO_DEPTH)) begin
               issue = 1'b1;
               if (remaining_reg == 11'd1)
                  state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && strm.m_last) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr_reg   <= '0;
         next_addr_reg  <= '0;
         remaining_reg  <= '0;
         s1_reg         <= 1'b0;
         s1_last_reg    <= 1'b0;
         s2_reg         <= 1'b0;
         s2_last_reg    <= 1'b0;
         done_reg       <= 1'b0;
         err_reg        <= 1'b0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_count_reg <= '0;
      end else begin
         done_reg    <= done_next;
         err_reg     <= err_next;
         s1_reg      <= issue;
         s1_last_reg <= issue & issue_last;
         s2_reg      <= s1_reg;
         s2_last_reg <= s1_last_reg;
         if (issue) begin
            mem_addr_reg  <= issue_addr;
            next_addr_reg <= addr_inc;
            remaining_reg <= cmd_load ? (word_count - 11'd1) : (remaining_reg - 11'd1);
         end
         if (push)
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         unique case ({push, pop})
            2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
            2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
            default: fifo_count_reg <= fifo_count_reg;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
         logic [31:0] data_reg;
         logic        last_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_reg <= '0;
               last_reg <= 1'b0;
            end else if (push && (wr_ptr_reg == PW'(gi))) begin
               data_reg <= mem_rdata;
               last_reg <= s2_last_reg;
            end
         end
         assign entry_data[gi] = data_reg;
         assign entry_last[gi] = last_reg;
      end
   endgenerate

   assign mem_addr     = mem_addr_reg;
   assign strm.m_valid = (fifo_count_reg != '0);
   assign strm.m_data  = entry_data[rd_ptr_reg];
   assign strm.m_last  = strm.m_valid & entry_last[rd_ptr_reg];
   assign busy         = (state_reg != IDLE);
   assign done         = done_reg;
   assign err          = err_reg;
endmodule

// File: tb/tb_prx32_rom_streamer.sv
// Directed bench for prx32_rom_streamer: a table of commands with hand-computed
// boundary words, plus hand-written reset-abort and zero-count sequences.
module tb_prx32_rom_streamer;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] base_addr;
   logic [10:0] word_count;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        busy, done, err;

   prx32_rom_streamer_if strm ();

   prx32_rom_streamer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .strm       (strm),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   logic [31:0] rom [1024];
   always @(posedge clk) mem_rdata <= rom[mem_addr[11:2]];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] beat_addr(input logic [31:0] base, input int i);
      logic [31:0] a;
      a = base + 32'(4 * i);
`ifdef PRX32_ROM_STREAMER_WRAP_EN
      a = {20'b0, a[11:0]};
`endif
      return a;
   endfunction

   typedef struct {
      logic [31:0] base;
      logic [10:0] count;
      int          ready_mode;  // 0: always ready, 1: ready one cycle in three
      bit          exp_err;
      logic [31:0] exp_first;
      logic [31:0] exp_final;
   } vec_t;

   task automatic run_vec(input vec_t v, input int idx);
      logic [31:0] addr_before;
      logic [31:0] held_data;
      logic        held_last;
      bit          stalled;
      bit          seen_valid;
      bit          finished;
      int          i;
      int          n;
      logic [31:0] exp_d;

      @(negedge clk);
      addr_before = mem_addr;
      start       = 1'b1;
      base_addr   = v.base;
      word_count  = v.count;
      strm.m_ready = (v.ready_mode == 0);
      @(negedge clk);
      start = 1'b0;
      $display("vec %0d: base=%h count=%0d ready_mode=%0d", idx, v.base, v.count, v.ready_mode);

      if (v.exp_err) begin
         chk("err_pulse", {31'b0, err}, 32'd1);
         chk("err_busy", {31'b0, busy}, 32'd0);
         chk("err_valid", {31'b0, strm.m_valid}, 32'd0);
         chk("err_mem_addr", mem_addr, addr_before);
         chk("err_done", {31'b0, done}, 32'd0);
         @(negedge clk);
         chk("err_one_cycle", {31'b0, err}, 32'd0);
         return;
      end
      if (v.count == 11'd0) begin
         chk("zero_done", {31'b0, done}, 32'd1);
         chk("zero_busy", {31'b0, busy}, 32'd0);
         chk("zero_err", {31'b0, err}, 32'd0);
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("zero_valid", {31'b0, strm.m_valid}, 32'd0);
            chk("zero_done_once", {31'b0, done}, 32'd0);
         end
         return;
      end

      chk("run_busy", {31'b0, busy}, 32'd1);
      chk("run_mem_addr0", mem_addr, v.base);
      n = int'(v.count);
      i = 0;
      stalled = 1'b0;
      seen_valid = 1'b0;
      finished = 1'b0;
      held_data = '0;
      held_last = 1'b0;
      for (int c = 0; c < 5000 && !finished; c++) begin
         if (c == 1 && n > 1)
            chk("mem_addr1", mem_addr, beat_addr(v.base, 1));
         if (stalled) begin
            chk("stall_valid", {31'b0, strm.m_valid}, 32'd1);
            chk("stall_data", strm.m_data, held_data);
            chk("stall_last", {31'b0, strm.m_last}, {31'b0, held_last});
         end
         if (!seen_valid && strm.m_valid) begin
            seen_valid = 1'b1;
            chk("first_latency", 32'(c), 32'd2);
         end
         strm.m_ready = (v.ready_mode == 0) ? 1'b1 : ((c % 3) == 2);
         if (strm.m_valid && strm.m_ready) begin
            if (i == 0)
               exp_d = v.exp_first;
            else if (i == n - 1)
               exp_d = v.exp_final;
            else
               exp_d = rom[beat_addr(v.base, i) >> 2];
            chk("beat_data", strm.m_data, exp_d);
            chk("beat_last", {31'b0, strm.m_last}, {31'b0, (i == n - 1)});
            if (v.ready_mode == 0)
               chk("beat_cycle", 32'(c), 32'(2 + i));
            i++;
            if (strm.m_last || i == n) begin
               @(negedge clk);
               chk("done_pulse", {31'b0, done}, 32'd1);
               chk("busy_fall", {31'b0, busy}, 32'd0);
               @(negedge clk);
               chk("done_one_cycle", {31'b0, done}, 32'd0);
               finished = 1'b1;
            end
         end else begin
            chk("no_early_done", {31'b0, done}, 32'd0);
         end
         stalled   = strm.m_valid && !strm.m_ready;
         held_data = strm.m_data;
         held_last = strm.m_last;
         if (!finished)
            @(negedge clk);
      end
      if (!finished)
         chk("beat_timeout", 32'(i), 32'(n));
      strm.m_ready = 1'b1;
   endtask

   vec_t vecs [10];

   initial begin
      for (int k = 0; k < 1024; k++)
         rom[k] = 32'hA000_0000 | 32'(k);
      rom[0] = 32'h1;
      rom[1] = 32'h3;
      rom[2] = 32'h7;
      rom[3] = 32'hF;
      rom[4] = 32'hFF;
      rom[1023] = 32'hDEAD_0FFC;

      vecs[0] = '{32'h000, 11'd5,    0, 1'b0, 32'h1, 32'hFF};
      vecs[1] = '{32'h000, 11'd5,    1, 1'b0, 32'h1, 32'hFF};
      vecs[2] = '{32'h002, 11'd1,    0, 1'b1, 32'h0, 32'h0};
`ifdef PRX32_ROM_STREAMER_WRAP_EN
      vecs[3] = '{32'hFFC, 11'd3,    0, 1'b0, 32'hDEAD_0FFC, 32'h3};
      vecs[6] = '{32'hFF8, 11'd3,    1, 1'b0, 32'hA000_03FE, 32'h1};
      vecs[9] = '{32'h004, 11'd1024, 0, 1'b0, 32'h3, 32'h1};
`else
      vecs[3] = '{32'hFFC, 11'd3,    0, 1'b1, 32'h0, 32'h0};
      vecs[6] = '{32'hFF8, 11'd3,    1, 1'b1, 32'h0, 32'h0};
      vecs[9] = '{32'h004, 11'd1024, 0, 1'b1, 32'h0, 32'h0};
`endif
      vecs[4] = '{32'h000, 11'd0,    0, 1'b0, 32'h0, 32'h0};
      vecs[5] = '{32'h00C, 11'd2,    0, 1'b0, 32'hF, 32'hFF};
      vecs[7] = '{32'hFFC, 11'd1,    1, 1'b0, 32'hDEAD_0FFC, 32'hDEAD_0FFC};
      vecs[8] = '{32'h000, 11'd1024, 0, 1'b0, 32'h1, 32'hDEAD_0FFC};

      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      word_count = '0;
      strm.m_ready = 1'b1;
      #1;
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_valid", {31'b0, strm.m_valid}, 32'd0);
      chk("rst_data", strm.m_data, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 10; v++)
         run_vec(vecs[v], v);

      // abort a running command with an asynchronous reset after two beats
      @(negedge clk);
      start = 1'b1;
      base_addr = 32'h0;
      word_count = 11'd5;
      strm.m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      $display("reset asserted mid-command");
      chk("arst_mem_addr", mem_addr, 32'h0);
      chk("arst_valid", {31'b0, strm.m_valid}, 32'd0);
      chk("arst_data", strm.m_data, 32'h0);
      chk("arst_last", {31'b0, strm.m_last}, 32'd0);
      chk("arst_busy", {31'b0, busy}, 32'd0);
      chk("arst_done", {31'b0, done}, 32'd0);
      chk("arst_err", {31'b0, err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("arst_no_stale_beat", {31'b0, strm.m_valid}, 32'd0);
      end
      run_vec('{32'h008, 11'd1, 0, 1'b0, 32'h7, 32'h7}, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
